// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-Stream elastic buffer slice.
// Provides count/pointer width helpers and a power-of-two check.
package axis_pkg;

    // Width able to hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // Pointer width for n entries; one bit minimum.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_elastic_buffer_if.sv
// Handshake bundle for axis_elastic_buffer.
// Ports: i_flush, i_valid/o_ready/i_data/i_last upstream,
//        o_valid/i_ready/o_data/o_last downstream, o_count, o_afull.
// slave = buffer side, master = producer/consumer side.
interface axis_elastic_buffer_if
    import axis_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int DEPTH   = 4
);
    localparam int NB_CNT = cnt_width(DEPTH);

    logic               i_flush;
    logic               i_valid;
    logic               o_ready;
    logic [NB_DATA-1:0] i_data;
    logic               i_last;
    logic               o_valid;
    logic               i_ready;
    logic [NB_DATA-1:0] o_data;
    logic               o_last;
    logic [NB_CNT-1:0]  o_count;
    logic               o_afull;

    modport slave (
        input  i_flush,
        input  i_valid,
        input  i_data,
        input  i_last,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_data,
        output o_last,
        output o_count,
        output o_afull
    );

    modport master (
        output i_flush,
        output i_valid,
        output i_data,
        output i_last,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_data,
        input  o_last,
        input  o_count,
        input  o_afull
    );

endinterface

// File: rtl/elastic_buffer_ring.sv
// Circular register array backing the elastic buffer.
// Ports: i_clk, i_rst, i_flush, write (i_wr_en, i_wr_data),
//        read-advance (i_rd_en), o_rd_data = oldest entry.
module elastic_buffer_ring
    import axis_pkg::*;
#(
    parameter int NB_WIDTH = 33,
    parameter int N_ENTRY  = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_wr_en,
    input  logic [NB_WIDTH-1:0] i_wr_data,
    input  logic                i_rd_en,
    output logic [NB_WIDTH-1:0] o_rd_data
);

    localparam int NB_PTR = ptr_width(N_ENTRY);
    localparam logic [NB_PTR-1:0] PTR_LAST = NB_PTR'(N_ENTRY - 1);

    logic [NB_WIDTH-1:0] mem [N_ENTRY];
    logic [NB_PTR-1:0]   wr_ptr;
    logic [NB_PTR-1:0]   rd_ptr;

    // N_ENTRY need not be a power of two, so wrap explicitly.
    function automatic logic [NB_PTR-1:0] ptr_inc(
        input logic [NB_PTR-1:0] p
    );
        return (p == PTR_LAST) ? '0 : p + NB_PTR'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (i_wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (i_rd_en) rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Payload needs no reset; occupancy lives in the parent.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem[wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = mem[rd_ptr];

endmodule

// File: rtl/axis_elastic_buffer.sv
// DEPTH-beat AXI-Stream elastic buffer, all outputs from flops.
// Ports: i_clk, i_rst (sync, active-high), bus (slave modport).
module axis_elastic_buffer
    import axis_pkg::*;
#(
    parameter int NB_DATA   = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input logic                  i_clk,
    input logic                  i_rst,
    axis_elastic_buffer_if.slave bus
);

    localparam int NB_CNT = cnt_width(DEPTH);

    typedef struct packed {
        logic [NB_DATA-1:0] data;
        logic               last;
    } beat_t;

    localparam int NB_BEAT = $bits(beat_t);
    localparam int NB_RING = DEPTH - 1;

    localparam logic [NB_CNT-1:0] CNT_FULL  = NB_CNT'(DEPTH);
    localparam logic [NB_CNT-1:0] CNT_AFULL = NB_CNT'(AFULL_LVL);
    localparam logic [NB_CNT-1:0] CNT_ONE   = NB_CNT'(1);

    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end

    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("AFULL_LVL must be in 1..DEPTH");
    end

    logic              push;
    logic              pop;
    logic              head_load;
    logic              ring_has;
    logic              take_ring;
    logic              take_in;
    logic              wr_en;
    logic [NB_CNT-1:0] count_q;
    logic [NB_CNT-1:0] count_next;
    logic              valid_q;
    logic              ready_q;
    logic              afull_q;
    beat_t             head_q;
    beat_t             in_beat;
    beat_t             ring_beat;

    assign in_beat = '{data: bus.i_data, last: bus.i_last};

    always_comb begin
        push      = bus.i_valid & ready_q;
        pop       = valid_q & bus.i_ready;
        head_load = ~valid_q | pop;
        // Head is always filled first, so the array
        // holds beats only when count exceeds one.
        ring_has  = count_q > CNT_ONE;
        take_ring = head_load & ring_has & ~bus.i_flush;
        take_in   = head_load & ~ring_has & push
                  & ~bus.i_flush;
        wr_en     = push & ~take_in & ~bus.i_flush;
        if (bus.i_flush) begin
            count_next = '0;
        end else begin
            count_next = count_q + NB_CNT'(push)
                       - NB_CNT'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            afull_q <= 1'b0;
            head_q  <= '0;
        end else begin
            count_q <= count_next;
            valid_q <= count_next != '0;
            ready_q <= count_next < CNT_FULL;
            afull_q <= count_next >= CNT_AFULL;
            if (take_ring) begin
                head_q <= ring_beat;
            end else if (take_in) begin
                head_q <= in_beat;
            end
        end
    end

    elastic_buffer_ring #(
        .NB_WIDTH (NB_BEAT),
        .N_ENTRY  (NB_RING)
    ) u_ring (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_flush   (bus.i_flush),
        .i_wr_en   (wr_en),
        .i_wr_data (in_beat),
        .i_rd_en   (take_ring),
        .o_rd_data (ring_beat)
    );

    assign bus.o_valid = valid_q;
    assign bus.o_ready = ready_q;
    assign bus.o_afull = afull_q;
    assign bus.o_count = count_q;
    assign bus.o_data  = head_q.data;
    assign bus.o_last  = head_q.last;

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Self-checking bench for axis_elastic_buffer.
// Two instances: DEPTH=4 (main) and DEPTH=2 (streaming).
module tb_axis_elastic_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    axis_elastic_buffer_if #(.NB_DATA(32), .DEPTH(4)) bus4 ();
    axis_elastic_buffer_if #(.NB_DATA(32), .DEPTH(2)) bus2 ();

    axis_elastic_buffer #(
        .NB_DATA(32), .DEPTH(4), .AFULL_LVL(3)
    ) u_dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus4)
    );

    axis_elastic_buffer #(
        .NB_DATA(32), .DEPTH(2), .AFULL_LVL(1)
    ) u_dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2)
    );

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t m4[$];
    beat_t m2[$];
    int errs   = 0;
    int checks = 0;

    // Apply inputs for one edge and advance the queue model.
    task automatic drive4(input bit v, input logic [31:0] d,
                          input bit l, input bit r,
                          input bit fl, input bit rs);
        bit pu, po;
        bus4.i_valid = v;
        bus4.i_data  = d;
        bus4.i_last  = l;
        bus4.i_ready = r;
        bus4.i_flush = fl;
        rst          = rs;
        pu = v && (m4.size() < 4);
        po = r && (m4.size() != 0);
        if (rs || fl) begin
            m4.delete();
            if (rs) m2.delete();
        end else begin
            if (po) void'(m4.pop_front());
            if (pu) m4.push_back('{d, l});
        end
        @(negedge clk);
    endtask

    task automatic drive2(input bit v, input logic [31:0] d,
                          input bit r);
        bit pu, po;
        bus2.i_valid = v;
        bus2.i_data  = d;
        bus2.i_last  = 1'b0;
        bus2.i_ready = r;
        bus2.i_flush = 1'b0;
        pu = v && (m2.size() < 2);
        po = r && (m2.size() != 0);
        if (po) void'(m2.pop_front());
        if (pu) m2.push_back('{d, 1'b0});
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus4.i_valid = 0; bus4.i_ready = 0; bus4.i_flush = 0;
        bus4.i_data  = 0; bus4.i_last  = 0;
        bus2.i_valid = 0; bus2.i_ready = 0; bus2.i_flush = 0;
        bus2.i_data  = 0; bus2.i_last  = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        m4.delete();
        m2.delete();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus4.o_ready, bus4.o_valid, bus4.o_afull}
            !== 3'b100) begin
            errs++;
            $display("FAIL reset_flags got=%b exp=100",
                     {bus4.o_ready, bus4.o_valid,
                      bus4.o_afull});
        end
        checks++;
        if (bus4.o_count !== 3'd0) begin
            errs++;
            $display("FAIL reset_count got=%0d exp=0",
                     bus4.o_count);
        end
        checks++;
        if ({bus4.o_data, bus4.o_last} !== 33'd0) begin
            errs++;
            $display("FAIL reset_data got=%h/%b exp=0/0",
                     bus4.o_data, bus4.o_last);
        end
        checks++;
        if ({bus2.o_ready, bus2.o_valid, bus2.o_count}
            !== 4'b1000) begin
            errs++;
            $display("FAIL reset_d2 got=%b exp=1000",
                     {bus2.o_ready, bus2.o_valid,
                      bus2.o_count});
        end
        drive4(1, 32'hA1, 0, 0, 0, 0);
        checks++;
        if ({bus4.o_valid, bus4.o_data, bus4.o_count}
            !== {1'b1, 32'hA1, 3'd1}) begin
            errs++;
            $display("FAIL first_push got=%b/%h/%0d exp=1/a1/1",
                     bus4.o_valid, bus4.o_data, bus4.o_count);
        end
    endtask

    task automatic test_fill();
        drive4(0, 0, 0, 0, 1, 0);
        checks++;
        if (bus4.o_count !== 3'd0) begin
            errs++;
            $display("FAIL fill_flush got=%0d exp=0",
                     bus4.o_count);
        end
        for (int k = 1; k <= 4; k++) begin
            drive4(1, 32'(k), 0, 0, 0, 0);
            checks++;
            if (bus4.o_count !== 3'(k)) begin
                errs++;
                $display("FAIL fill_count got=%0d exp=%0d",
                         bus4.o_count, k);
            end
            checks++;
            if (bus4.o_afull !== (k >= 3)) begin
                errs++;
                $display("FAIL fill_afull k=%0d got=%b",
                         k, bus4.o_afull);
            end
            checks++;
            if (bus4.o_ready !== (k < 4)) begin
                errs++;
                $display("FAIL fill_ready k=%0d got=%b",
                         k, bus4.o_ready);
            end
            checks++;
            if (bus4.o_data !== 32'h01) begin
                errs++;
                $display("FAIL fill_head got=%h exp=01",
                         bus4.o_data);
            end
        end
        drive4(1, 32'h05, 0, 0, 0, 0);
        checks++;
        if ({bus4.o_count, bus4.o_ready, bus4.o_data}
            !== {3'd4, 1'b0, 32'h01}) begin
            errs++;
            $display("FAIL full_reject got=%0d/%b/%h exp=4/0/01",
                     bus4.o_count, bus4.o_ready, bus4.o_data);
        end
    endtask

    task automatic test_drain();
        drive4(0, 0, 0, 1, 0, 0);
        checks++;
        if ({bus4.o_count, bus4.o_ready, bus4.o_data}
            !== {3'd3, 1'b1, 32'h02}) begin
            errs++;
            $display("FAIL drain_first got=%0d/%b/%h exp=3/1/02",
                     bus4.o_count, bus4.o_ready, bus4.o_data);
        end
        for (int k = 3; k <= 4; k++) begin
            drive4(0, 0, 0, 1, 0, 0);
            checks++;
            if ({bus4.o_data, bus4.o_count}
                !== {32'(k), 3'(5 - k)}) begin
                errs++;
                $display("FAIL drain_order got=%h/%0d exp=%h/%0d",
                         bus4.o_data, bus4.o_count, k, 5 - k);
            end
        end
        drive4(0, 0, 0, 1, 0, 0);
        checks++;
        if ({bus4.o_valid, bus4.o_count} !== 4'b0000) begin
            errs++;
            $display("FAIL drain_empty got=%b/%0d exp=0/0",
                     bus4.o_valid, bus4.o_count);
        end
        drive4(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_stream2();
        int pops = 0;
        for (int c = 0; c <= 100; c++) begin
            if (c > 0) begin
                checks++;
                if ({bus2.o_valid, bus2.o_ready, bus2.o_count,
                     bus2.o_data}
                    !== {1'b1, 1'b1, 2'd1, 32'(c - 1)}) begin
                    errs++;
                    $display("FAIL stream c=%0d got=%b/%b/%0d/%0d",
                             c, bus2.o_valid, bus2.o_ready,
                             bus2.o_count, bus2.o_data);
                end else begin
                    pops++;
                end
            end
            drive2(c < 100, 32'(c), 1);
        end
        checks++;
        if (pops != 100 || bus2.o_valid !== 1'b0) begin
            errs++;
            $display("FAIL stream_total got=%0d/%b exp=100/0",
                     pops, bus2.o_valid);
        end
        drive2(0, 0, 0);
    endtask

    task automatic test_random();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit v, r, l, hold;
        logic [31:0] d, hold_d;
        logic [5:0]  exp_f;
        hold   = 0;
        hold_d = '0;
        while (got < 10000 && cyc < 60000) begin
            exp_f = {m4.size() != 0, m4.size() < 4,
                     m4.size() >= 3, 3'(m4.size())};
            checks++;
            if ({bus4.o_valid, bus4.o_ready, bus4.o_afull,
                 bus4.o_count} !== exp_f) begin
                errs++;
                $display("FAIL rnd_flags cyc=%0d got=%b exp=%b",
                         cyc, {bus4.o_valid, bus4.o_ready,
                         bus4.o_afull, bus4.o_count}, exp_f);
            end
            if (m4.size() != 0) begin
                checks++;
                if ({bus4.o_data, bus4.o_last}
                    !== {m4[0].d, m4[0].l}) begin
                    errs++;
                    $display("FAIL rnd_data cyc=%0d got=%h/%b exp=%h/%b",
                             cyc, bus4.o_data, bus4.o_last,
                             m4[0].d, m4[0].l);
                end
            end
            if (hold) begin
                checks++;
                if (bus4.o_data !== hold_d) begin
                    errs++;
                    $display("FAIL rnd_stable got=%h exp=%h",
                             bus4.o_data, hold_d);
                end
            end
            v = (sent < 10000) && ($urandom_range(1) == 1);
            r = ($urandom_range(1) == 1);
            d = $urandom;
            l = (sent % 7) == 6;
            hold   = (m4.size() != 0) && !r;
            hold_d = (m4.size() != 0) ? m4[0].d : '0;
            if (v && m4.size() < 4) sent++;
            if (r && m4.size() != 0) got++;
            drive4(v, d, l, r, 0, 0);
            cyc++;
        end
        checks++;
        if (got != 10000) begin
            errs++;
            $display("FAIL rnd_timeout got=%0d exp=10000", got);
        end
        while (m4.size() != 0 && cyc < 60100) begin
            drive4(0, 0, 0, 1, 0, 0);
            cyc++;
        end
        drive4(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++)
            drive4(1, 32'h10 + 32'(k), 0, 0, 0, 0);
        checks++;
        if (bus4.o_count !== 3'd3) begin
            errs++;
            $display("FAIL flush_pre got=%0d exp=3",
                     bus4.o_count);
        end
        drive4(1, 32'h99, 0, 1, 1, 0);
        checks++;
        if ({bus4.o_valid, bus4.o_ready, bus4.o_afull,
             bus4.o_count} !== 6'b010000) begin
            errs++;
            $display("FAIL flush_state got=%b exp=010000",
                     {bus4.o_valid, bus4.o_ready,
                      bus4.o_afull, bus4.o_count});
        end
        drive4(1, 32'h55, 0, 0, 0, 0);
        checks++;
        if ({bus4.o_valid, bus4.o_data, bus4.o_count}
            !== {1'b1, 32'h55, 3'd1}) begin
            errs++;
            $display("FAIL flush_after got=%b/%h/%0d exp=1/55/1",
                     bus4.o_valid, bus4.o_data, bus4.o_count);
        end
        drive4(1, 32'h56, 0, 0, 0, 0);
        drive4(1, 32'h57, 1, 0, 0, 0);
        checks++;
        if (bus4.o_count !== 3'd3) begin
            errs++;
            $display("FAIL rst_pre got=%0d exp=3",
                     bus4.o_count);
        end
        drive4(1, 32'h99, 1, 1, 1, 1);
        checks++;
        if ({bus4.o_valid, bus4.o_ready, bus4.o_afull,
             bus4.o_count} !== 6'b010000) begin
            errs++;
            $display("FAIL rst_state got=%b exp=010000",
                     {bus4.o_valid, bus4.o_ready,
                      bus4.o_afull, bus4.o_count});
        end
        checks++;
        if ({bus4.o_data, bus4.o_last} !== 33'd0) begin
            errs++;
            $display("FAIL rst_data got=%h/%b exp=0/0",
                     bus4.o_data, bus4.o_last);
        end
        drive4(1, 32'h55, 0, 0, 0, 0);
        checks++;
        if ({bus4.o_valid, bus4.o_data, bus4.o_count}
            !== {1'b1, 32'h55, 3'd1}) begin
            errs++;
            $display("FAIL rst_after got=%b/%h/%0d exp=1/55/1",
                     bus4.o_valid, bus4.o_data, bus4.o_count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream2();
        test_random();
        test_flush();
        $display("Result: errors=%0d of %0d checks",
                 errs, checks);
        $finish;
    end

endmodule

// File: doc/axis_elastic_buffer.md
# axis_elastic_buffer

Parametrised AXI-Stream elastic buffer, successor to the single-entry skid buffer. It holds up to DEPTH beats, and every output is driven directly from a flop: o_valid, o_data, o_last and o_ready, with no combinational path from i_ready to o_ready. It adds occupancy reporting, a programmable almost-full flag and a synchronous flush. It sits between AXIS pipeline stages wherever timing closure or burst absorption needs more than one slot.

## Interface
- NB_DATA, 32, payload width in bits.
- DEPTH, 4, number of beat slots; must be ≥2 and a power of two (elaboration error otherwise).
- AFULL_LVL, DEPTH-1, occupancy at which o_afull asserts; range 1..DEPTH.
- NB_CNT, $clog2(DEPTH+1), occupancy counter width (derived, not overridable).
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_flush  in  1  synchronous discard of all stored beats.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  registered; the buffer accepts the beat.
- i_data  in  NB_DATA  upstream payload.
- i_last  in  1  upstream packet end.
- o_valid  out  1  registered; downstream beat valid.
- i_ready  in  1  downstream accepts.
- o_data  out  NB_DATA  registered downstream payload.
- o_last  out  1  registered downstream packet end.
- o_count  out  NB_CNT  registered occupancy, including the beat presented at the output.
- o_afull  out  1  registered; asserted when o_count ≥ AFULL_LVL.

## Operation
- Push means i_valid & o_ready. Pop means o_valid & i_ready.
- Storage: one output register (head) plus a circular array of DEPTH-1 entries with write and read pointers. Pointers wrap modulo DEPTH-1 (a plain register when DEPTH=2).
- When head is empty or being popped, head loads the oldest array entry if one exists. Otherwise it loads the incoming beat directly (bypass). Otherwise it goes empty.
- A push that does not go to head is written to the array at the write pointer.
- Order is strictly FIFO. {data, last} travel together.
- Count update: count_next = count + push − pop.
- o_ready_next = (count_next < DEPTH). o_afull_next = (count_next ≥ AFULL_LVL). o_valid_next = (count_next ≠ 0).
- When full, o_ready=0, so a push cannot happen. A pop in that cycle raises o_ready the following cycle.
- A beat that is not popped must hold o_data and o_last stable.
- Flush: on i_flush=1, the next state is count=0, pointers=0, o_valid=0, o_ready=1, o_afull=0. Any push or pop in the flush cycle is discarded. The array and head payload contents are don't-care.
- Reset has priority over flush.

## Timing
- Reset values: o_valid=0, o_ready=1, o_count=0, o_afull=0, o_data='0, o_last=0.
- Latency: a push into an empty buffer at edge N gives o_valid=1 after edge N (one cycle).
- Throughput: one beat per cycle sustained with i_ready=1 at any DEPTH.
- Simultaneous push and pop at count=k (0<k<DEPTH): count stays k and o_ready is unchanged.
- Simultaneous push and pop at count=1: head loads the incoming beat directly (bypass).
- o_ready reflects the occupancy at the last edge, so upstream sees at most one cycle of stale ready. Capacity covers this exactly; no beat is lost.
- Reset asserted mid-packet returns all outputs to their reset values at the next edge. Partial packets are dropped without error signalling.

## Structure
- Shared package axis_pkg: clog2-based count-width helper; beat struct typedef {data, last} parametrised via a localparam in the module.
- A single-port register array with circular pointers goes in sub-module elastic_buffer_ring (parameters NB_DATA+1 and DEPTH-1). Head, count and flag logic stay in the top module.
- No other sub-modules; no vendor RAM inference required.

## Test plan
- Reset release, DEPTH=4: o_ready=1, o_valid=0, o_count=0 in the first cycle. Push 0xA1 → o_valid=1, o_data=0xA1, o_count=1 in the next cycle.
- Fill with i_ready=0, pushing 0x01..0x04 → o_ready=0 after the 4th push, o_count=4, o_afull=1 from count 3 (AFULL_LVL=3). A 5th i_valid beat 0x05 is not accepted.
- Full buffer, then i_ready=1 for one cycle → 0x01 popped, o_ready=1 the next cycle, o_count=3. Drain yields 0x02, 0x03, 0x04 in order.
- Streaming with i_valid=i_ready=1 for 100 beats of incrementing data, DEPTH=2 → 100 pops in 101 cycles, no gaps after the first, o_count constant at 1.
- Random i_valid/i_ready at 50% for 10k beats with o_last every 7th beat → scoreboard matches data and last exactly; o_data stable while o_valid & ~i_ready.
- Count=3, assert i_flush together with push and pop → next cycle o_valid=0, o_count=0, o_ready=1. A subsequent push of 0x55 appears as the next output. Repeat the sequence with i_rst=1 to confirm reset values are restored.
